// File: rtl/ex_ctrl_pkg.sv
// Shared types and defaults for the Execute-stage hazard controller:
// FSM state encoding, forwarding-mux encodings and pipeline slot records.
package ex_ctrl_pkg;

    // Default datapath / branch-target width.
    localparam int XLEN_DEF  = 64;
    // Default performance-counter width.
    localparam int CNT_W_DEF = 32;

    // Last action taken by the controller. Recorded only; never gates detection.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_e;

    // Operand source select for the instruction currently in EX.
    //   FWD_RF  : value read from the register file in ID
    //   FWD_WB  : value produced by the instruction now in MEM/WB
    //   FWD_MEM : value produced by the instruction now in EX/MEM
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Destination-tracking record for the instruction in EX.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       mem_read;
        logic       reg_write;
        logic       is_branch;
    } ex_slot_t;

    // Destination-tracking record for the instruction in MEM.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       reg_write;
    } mem_slot_t;

    // True when a live producer writing rd matches a source index.
    // x0 is hard-wired to zero, so it never matches.
    function automatic logic rd_hit(input logic       live,
                                    input logic [4:0] rd,
                                    input logic [4:0] src);
        return live && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/ex_forward_sel.sv
// Operand forwarding comparator for one source register. The producer in
// EX (youngest) takes priority over the producer in MEM. Purely
// combinational; the caller registers the result when ID is accepted.
module ex_forward_sel
    import ex_ctrl_pkg::*;
(
    input  logic       op_used,
    input  logic [4:0] src,
    input  logic       ex_v,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       mem_v,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    output logic [1:0] sel
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = rd_hit(ex_v && ex_reg_write, ex_rd, src);
    assign mem_match = rd_hit(mem_v && mem_reg_write, mem_rd, src);

    // Priority select: youngest producer wins, unused operands read the RF.
    always_comb begin
        sel = FWD_RF;
        if (op_used) begin
            if (ex_match) begin
                sel = FWD_MEM;
            end else if (mem_match) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard controller. Tracks the instructions in EX and MEM,
// detects load-use hazards and taken branches, drives PC / IF/ID / ID/EX
// control, selects operand forwarding for the next instruction in EX, and
// counts stall and flush events with saturating counters.
//
// Priority: a taken branch squashes the younger instruction in ID anyway,
// so it overrides a simultaneous load-use stall, which is then neither
// applied nor counted.
module ex_hazard_controller
    import ex_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs2,
    input  logic             id_mem_read,
    input  logic             id_reg_write,
    input  logic             id_is_branch,
    input  logic             ex_zero,
    input  logic [XLEN-1:0]  ex_target,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pc_sel,
    output logic [XLEN-1:0]  pc_target,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_slot_t    ex_q;
    mem_slot_t   mem_q;
    ctrl_state_e state;

    logic       load_use;
    logic       branch_taken;
    logic       stall;
    logic       accept;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // Hazard detection against the instruction currently in EX.
    always_comb begin
        load_use     = id_valid
                       && (rd_hit(ex_q.v && ex_q.mem_read, ex_q.rd, id_rs1)
                           || (id_uses_rs2
                               && rd_hit(ex_q.v && ex_q.mem_read, ex_q.rd, id_rs2)));
        branch_taken = ex_q.v && ex_q.is_branch && ex_zero;
        stall        = load_use && !branch_taken;
    end

    // ID moves into EX only when something valid is there and no bubble is forced.
    assign accept = id_valid && !branch_taken && !load_use;

    // Same-cycle pipeline control; branch redirect outranks the load-use stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = '0;
        if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_sel      = 1'b1;
            pc_target   = ex_target;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Operand comparators for the instruction waiting in ID.
    ex_forward_sel u_fwd_rs1 (
        .op_used       (1'b1),
        .src           (id_rs1),
        .ex_v          (ex_q.v),
        .ex_reg_write  (ex_q.reg_write),
        .ex_rd         (ex_q.rd),
        .mem_v         (mem_q.v),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .sel           (sel_a)
    );

    ex_forward_sel u_fwd_rs2 (
        .op_used       (id_uses_rs2),
        .src           (id_rs2),
        .ex_v          (ex_q.v),
        .ex_reg_write  (ex_q.reg_write),
        .ex_rd         (ex_q.rd),
        .mem_v         (mem_q.v),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .sel           (sel_b)
    );

    // Advance the EX and MEM tracking slots; a rejected ID becomes a bubble in EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q.v         <= ex_q.v;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            if (accept) begin
                ex_q.v         <= 1'b1;
                ex_q.rd        <= id_rd;
                ex_q.mem_read  <= id_mem_read;
                ex_q.reg_write <= id_reg_write;
                ex_q.is_branch <= id_is_branch;
            end else begin
                ex_q <= '0;
            end
        end
    end

    // Forwarding selects travel with the instruction into EX; bubbles read the RF.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (accept) begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end else begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end
    end

    // Saturating event counters: applied stalls and taken branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Record of the last action taken: FLUSH > STALL > RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else if (branch_taken) begin
            state <= FLUSH;
        end else if (load_use) begin
            state <= STALL;
        end else begin
            state <= RUN;
        end
    end

    // Any stall or flush leaves a bubble behind it, so EX must be empty then.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (state == RUN || !ex_q.v);
        end
    end

endmodule

// File: doc/ex_hazard_controller.md
EX_HAZARD_CONTROLLER -- requirements
Module: ex_hazard_controller

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the datapath and branch-target width.
REQ-002 Parameter CNT_W, default 32, SHALL set the width of the performance counters.
REQ-003 Ports SHALL be exactly as listed below (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1, id_rs2, id_rd  in  5 each  ID source and destination register indices.
- id_uses_rs2, id_mem_read, id_reg_write, id_is_branch  in  1 each  ID decode flags.
- ex_zero  in  1  Zero flag from the Execute datapath.
- ex_target  in  XLEN  branch target from the Execute datapath.
- pc_write, ifid_write  out  1 each  PC and IF/ID register write enables.
- ifid_flush  out  1  squash IF/ID.
- idex_bubble  out  1  insert a NOP into ID/EX.
- pc_sel  out  1  1 selects pc_target.
- pc_target  out  XLEN  redirect address.
- fwd_a, fwd_b  out  2 each  operand source for the instruction now in EX.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 The block SHALL track an EX slot (v, rd, mem_read, reg_write, is_branch) and a MEM slot (v, rd, reg_write) that advance every cycle: EX to MEM, and ID to EX when id_valid is 1 and idex_bubble is 0; otherwise the EX slot loads v=0.
REQ-006 Load-use hazard SHALL be: id_valid & ex.v & ex.mem_read & ex.rd!=0 & (ex.rd==id_rs1 | (id_uses_rs2 & ex.rd==id_rs2)).
REQ-007 Branch-taken SHALL be: ex.v & ex.is_branch & ex_zero.
REQ-008 On branch-taken, in the same cycle (combinational): pc_sel=1, pc_target=ex_target, ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
REQ-009 On load-use without branch-taken, in the same cycle: pc_write=0, ifid_write=0, idex_bubble=1, pc_sel=0.
REQ-010 If both conditions hold, branch-taken SHALL win and the stall SHALL be suppressed and not counted.
REQ-011 With neither condition: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pc_sel=0, pc_target=0.
REQ-012 A registered FSM SHALL hold states RUN, STALL, FLUSH, entered at each clock edge from the condition seen that cycle (FLUSH > STALL > RUN); it SHALL record the last action only and SHALL NOT gate detection.
REQ-013 fwd_a and fwd_b SHALL be registered and computed at ID acceptance, per operand x in {rs1, rs2}:
- 2'b10 if ex.v & ex.reg_write & ex.rd!=0 & ex.rd==id_x.
- else 2'b01 if mem.v & mem.reg_write & mem.rd!=0 & mem.rd==id_x.
- else 2'b00.
- fwd_b SHALL be 00 when id_uses_rs2=0.
REQ-014 When the EX slot loads a bubble, fwd_a and fwd_b SHALL load 00 (latency: 1 cycle, aligned with the instruction in EX).
REQ-015 stall_cnt SHALL increment by 1 for each cycle in which a counted stall occurs; flush_cnt SHALL increment by 1 for each branch-taken cycle; both SHALL saturate at all-ones with no wrap.
REQ-016 Register x0 SHALL never cause a hazard or forwarding.

Reset
REQ-017 While reset is 1 at a clock edge, the block SHALL set: both slots v=0, FSM=RUN, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0.
REQ-018 Reset SHALL override any in-flight stall or flush; the cycle after reset SHALL show pc_write=1, ifid_write=1 and all other control outputs 0.

Structure
REQ-019 Package ex_ctrl_pkg SHALL hold the FSM state enum, the fwd encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10), and the defaults for XLEN and CNT_W.
REQ-020 The operand comparator SHALL be the sub-module ex_forward_sel, instantiated twice (rs1, rs2).

Verification
REQ-021 Load-use: ld x5 in EX, ID add rs1=x5 -> one cycle with pc_write=0 and idex_bubble=1, stall_cnt 0->1, then the add enters EX with fwd_a=01.
REQ-022 EX forwarding: add x3 in EX, ID sub rs2=x3, id_uses_rs2=1 -> next cycle fwd_b=10 and fwd_a=00.
REQ-023 Branch taken: branch in EX, ex_zero=1, ex_target=0x500 -> pc_sel=1, pc_target=0x500, ifid_flush=1, idex_bubble=1; next cycle EX slot invalid; flush_cnt=1.
REQ-024 Simultaneous events: branch taken plus load-use in the same cycle -> flush outputs only, pc_write=1, stall_cnt unchanged.
REQ-025 x0 check, then saturation: id_rd=0 producer -> fwd stays 00; with stall_cnt preloaded to all-ones, a further stall -> stall_cnt stays all-ones.
REQ-026 Reset mid-stall: assert reset during a load-use cycle -> next cycle all outputs at their reset values and counters 0.
